// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I datapath. Holds the instruction
// register, steps FETCH/DECODE/EXECUTE/MEM/WB and produces datapath controls.
module multicycle_control #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_req,
  input  logic        instr_ready,
  input  logic [31:0] instr_rdata,
  output logic [31:0] ir,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        ALUSrc_A,
  output logic        ALUSrc_B,
  output logic        RegWrite,
  output logic        Branch,
  output logic [1:0]  PCSrc,
  output logic [3:0]  ALUControl,
  output logic [1:0]  MemtoReg,
  output logic        PCWrite,
  output logic [2:0]  state_o,
  output logic        illegal_instr,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam bit          TIMEOUT_EN = (WAIT_LIMIT != 0);
  localparam logic [31:0] LIMIT_M1   = 32'(WAIT_LIMIT - 1);

  state_t      state, state_nx;
  logic [31:0] ir_q;
  logic [31:0] wait_cnt, wait_cnt_nx;
  logic        ill_q, bus_q;
  logic        ir_load, set_ill, set_bus;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_r, is_i_alu, is_load, is_store, is_branch;
  logic        is_jal, is_jalr, is_lui, is_auipc, is_legal;
  logic        wait_hit;
  logic [31:0] wait_inc;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign is_r      = (opcode == OP_R);
  assign is_i_alu  = (opcode == OP_I_ALU);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_legal  = is_r | is_i_alu | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;

  // Limit check is on the count before this cycle's increment, so the
  // WAIT_LIMIT-th consecutive not-ready cycle is the one that traps.
  assign wait_hit  = TIMEOUT_EN && (wait_cnt == LIMIT_M1);
  assign wait_inc  = (wait_cnt == '1) ? wait_cnt : wait_cnt + 32'd1;

  assign ir            = ir_q;
  assign state_o       = state;
  assign illegal_instr = ill_q;
  assign bus_error     = bus_q;

  // Datapath mux selects decoded from the IR in every state
  always_comb begin
    ALUSrc_A   = 1'b0;
    ALUSrc_B   = 1'b0;
    ALUControl = 4'b0000;
    MemtoReg   = 2'b00;
    case (opcode)
      OP_R: ALUControl = {ir_q[30], funct3};
      OP_I_ALU: begin
        ALUSrc_B   = 1'b1;
        ALUControl = {(funct3 == 3'b101) ? ir_q[30] : 1'b0, funct3};
      end
      OP_LOAD: begin
        ALUSrc_B = 1'b1;
        MemtoReg = 2'b01;
      end
      OP_STORE:  ALUSrc_B = 1'b1;
      OP_BRANCH: ALUControl = 4'b1000;
      OP_JAL:    MemtoReg = 2'b10;
      OP_JALR: begin
        ALUSrc_B = 1'b1;
        MemtoReg = 2'b10;
      end
      OP_LUI:    MemtoReg = 2'b11;
      OP_AUIPC: begin
        ALUSrc_A = 1'b1;
        ALUSrc_B = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state, strobes and wait-counter update
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = '0;
    instr_req   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    RegWrite    = 1'b0;
    PCWrite     = 1'b0;
    Branch      = 1'b0;
    PCSrc       = 2'b00;
    ir_load     = 1'b0;
    set_ill     = 1'b0;
    set_bus     = 1'b0;
    case (state)
      S_FETCH: begin
        instr_req = ~rst;
        if (instr_ready) begin
          ir_load  = 1'b1;
          state_nx = S_DECODE;
        end else if (wait_hit) begin
          set_bus  = 1'b1;
          state_nx = S_TRAP;
        end else begin
          wait_cnt_nx = wait_inc;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_nx = S_EXECUTE;
        end else begin
          set_ill  = 1'b1;
          state_nx = S_TRAP;
        end
      end
      S_EXECUTE: begin
        if (is_branch) begin
          Branch   = 1'b1;
          PCWrite  = 1'b1;
          PCSrc    = branch_taken ? 2'b01 : 2'b00;
          state_nx = S_FETCH;
        end else if (is_load || is_store) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ready) begin
          if (is_store) begin
            PCWrite  = 1'b1;
            state_nx = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end else if (wait_hit) begin
          set_bus  = 1'b1;
          state_nx = S_TRAP;
        end else begin
          wait_cnt_nx = wait_inc;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        if (is_jal)       PCSrc = 2'b10;
        else if (is_jalr) PCSrc = 2'b11;
        state_nx = S_FETCH;
      end
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_FETCH;
    endcase
  end

  // State, IR, wait counter and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      ir_q     <= NOP_INSTR;
      wait_cnt <= '0;
      ill_q    <= 1'b0;
      bus_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (ir_load) ir_q  <= instr_rdata;
      if (set_ill) ill_q <= 1'b1;
      if (set_bus) bus_q <= 1'b1;
    end
  end

endmodule
